// File: rtl/nv_nvdla_pdp_ingress_mux.sv
// PDP ingress: selects RDMA (off-flying) or SDP (on-the-fly) per layer, generates
// position flags for SDP beats, and registers the stream through a 2-entry skid buffer.
module nv_nvdla_pdp_ingress_mux #(
  parameter int DW = 64,
  parameter int FW = 12
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              reg2dp_op_en,
  input  logic              reg2dp_flying_mode,
  input  logic [1:0]        reg2dp_input_data,
  input  logic [12:0]       reg2dp_cube_in_width,
  input  logic [12:0]       reg2dp_cube_in_height,
  input  logic [12:0]       reg2dp_cube_in_channel,
  input  logic              rdma2dp_valid,
  output logic              rdma2dp_ready,
  input  logic [DW+FW-1:0]  rdma2dp_pd,
  input  logic              sdp2pdp_valid,
  output logic              sdp2pdp_ready,
  input  logic [DW-1:0]     sdp2pdp_pd,
  output logic              pre2cal_valid,
  input  logic              pre2cal_ready,
  output logic [DW+FW-1:0]  pre2cal_pd,
  output logic              busy,
  output logic              done,
  output logic [31:0]       dp2reg_perf_stall
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q;
  logic              off_fly_q;
  logic [12:0]       w_max_q, h_max_q;
  logic [13:0]       s_last_q;
  logic [12:0]       w_q, h_q;
  logic [9:0]        s_q;
  logic [1:0]        cnt_q;
  logic [DW+FW-1:0]  ent0_q, ent1_q;
  logic              done_q;
  logic [31:0]       stall_q;

  logic              start, in_rdy, in_vld, push, pop;
  logic              line_end, surf_end, cube_end;
  logic [FW-1:0]     gen_flags;
  logic [DW+FW-1:0]  in_pd;

  // Index of the last surface: ceil((C+1)/8) - 1 for int8, ceil((C+1)/4) - 1 otherwise.
  function automatic logic [13:0] surf_last(input logic [12:0] c, input logic [1:0] dt);
    logic [13:0] c1;
    c1 = {1'b0, c};
    if (dt == 2'd0) return ((c1 + 14'd8) >> 3) - 14'd1;
    return ((c1 + 14'd4) >> 2) - 14'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // An op_en coinciding with the done pulse must not start a layer.
  assign start    = (state_q == IDLE) & reg2dp_op_en & ~done_q;
  assign in_rdy   = (state_q == RUN) & (cnt_q != 2'd2);
  assign rdma2dp_ready = in_rdy & off_fly_q;
  assign sdp2pdp_ready = in_rdy & ~off_fly_q;
  assign in_vld   = off_fly_q ? rdma2dp_valid : sdp2pdp_valid;
  assign push     = in_vld & in_rdy;
  assign pop      = (cnt_q != 2'd0) & pre2cal_ready;

  assign line_end = (w_q == w_max_q);
  assign surf_end = line_end & (h_q == h_max_q);
  assign cube_end = surf_end & ({4'b0000, s_q} == s_last_q);

  always_comb begin
    gen_flags      = '0;
    gen_flags[8:0] = {s_q[4:0], cube_end, cube_end, surf_end, line_end};
  end

  assign in_pd = off_fly_q ? rdma2dp_pd : {gen_flags, sdp2pdp_pd};

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      off_fly_q <= 1'b0;
      w_max_q   <= '0;
      h_max_q   <= '0;
      s_last_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RUN;
          off_fly_q <= reg2dp_flying_mode;
          w_max_q   <= reg2dp_cube_in_width;
          h_max_q   <= reg2dp_cube_in_height;
          s_last_q  <= surf_last(reg2dp_cube_in_channel, reg2dp_input_data);
        end
        RUN: if (push & in_pd[DW+3]) state_q <= DRAIN;
        DRAIN: if ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pre2cal_ready)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Position counters: w fastest, then h, then surface.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst | start) begin
      w_q <= '0;
      h_q <= '0;
      s_q <= '0;
    end else if (push) begin
      if (line_end) begin
        w_q <= '0;
        if (surf_end) begin
          h_q <= '0;
          s_q <= s_q + 10'd1;
        end else begin
          h_q <= h_q + 13'd1;
        end
      end else begin
        w_q <= w_q + 13'd1;
      end
    end
  end

  // Skid buffer: occupancy is control, entry payloads carry no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) cnt_q <= 2'd0;
    else if (push & ~pop) cnt_q <= cnt_q + 2'd1;
    else if (pop & ~push) cnt_q <= cnt_q - 2'd1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    case ({push, pop})
      2'b10: if (cnt_q == 2'd0) ent0_q <= in_pd; else ent1_q <= in_pd;
      2'b01: ent0_q <= ent1_q;
      // push needs a free slot and pop a filled one, so exactly one entry is held here
      2'b11: ent0_q <= in_pd;
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst | start) stall_q <= '0;
    else if (pre2cal_valid & ~pre2cal_ready) stall_q <= sat_inc(stall_q);
  end

  assign pre2cal_valid     = (cnt_q != 2'd0);
  assign pre2cal_pd        = pre2cal_valid ? ent0_q : '0;
  assign busy              = (state_q != IDLE);
  assign done              = done_q;
  assign dp2reg_perf_stall = stall_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_ingress_mux.sv
// Bench for nv_nvdla_pdp_ingress_mux: table-driven layers, random layers against a
// loop-nest reference model, plus back-pressure and reset corner sequences.
module tb_nv_nvdla_pdp_ingress_mux;

  logic        clk = 1'b0;
  logic        rst, op_en, fly;
  logic [1:0]  dtype;
  logic [12:0] cw, ch, cc;
  logic        rvld, rrdy, svld, srdy, ovld, oready, busy, done;
  logic [75:0] rpd, opd;
  logic [63:0] spd;
  logic [31:0] stall;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  nv_nvdla_pdp_ingress_mux #(.DW(64), .FW(12)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en),
    .reg2dp_flying_mode(fly), .reg2dp_input_data(dtype),
    .reg2dp_cube_in_width(cw), .reg2dp_cube_in_height(ch), .reg2dp_cube_in_channel(cc),
    .rdma2dp_valid(rvld), .rdma2dp_ready(rrdy), .rdma2dp_pd(rpd),
    .sdp2pdp_valid(svld), .sdp2pdp_ready(srdy), .sdp2pdp_pd(spd),
    .pre2cal_valid(ovld), .pre2cal_ready(oready), .pre2cal_pd(opd),
    .busy(busy), .done(done), .dp2reg_perf_stall(stall)
  );

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one layer; the expected stream is built from the traversal rules as plain loop nests.
  task automatic run_layer(input bit fm, input logic [1:0] dt, input logic [12:0] W, H, C,
                           input int rpct, input int vpct, input bit poke,
                           output int nb, output logic [11:0] lf);
    logic [75:0] src[$];
    logic [75:0] expq[$];
    logic [11:0] rf[5];
    logic [11:0] fl;
    logic [63:0] d;
    bit le, se, ce, v;
    int S, si, oi, cyc, stall_e;
    rf = '{12'hA50, 12'hB41, 12'h872, 12'h963, 12'hE1C};
    S = (dt == 2'd0) ? (int'(C) + 8) / 8 : (int'(C) + 4) / 4;
    if (!fm) begin
      for (int s = 0; s < S; s++)
        for (int h = 0; h <= int'(H); h++)
          for (int w = 0; w <= int'(W); w++) begin
            le = (w == int'(W));
            se = le && (h == int'(H));
            ce = se && (s == S - 1);
            fl = {3'b000, s[4:0], ce, ce, se, le};
            d  = {$urandom, $urandom};
            src.push_back({fl, d});
            expq.push_back({fl, d});
          end
    end else begin
      for (int i = 0; i < 5; i++) begin
        d = {$urandom, $urandom};
        src.push_back({rf[i], d});
        expq.push_back({rf[i], d});
      end
      src.push_back({12'h00F, 64'hDEAD_BEEF_0000_0006});
    end
    fly = fm; dtype = dt; cw = W; ch = H; cc = C;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    chk("busy_start", 76'(busy), 76'd1);
    si = 0; oi = 0; cyc = 0; stall_e = 0; nb = 0; lf = '0;
    while (oi < expq.size() && cyc < 20000) begin
      v = (si < src.size()) && ($urandom_range(99) < vpct);
      rvld = fm & v;
      svld = ~fm & v;
      rpd  = (fm && si < src.size()) ? src[si] : '0;
      spd  = (!fm && si < src.size()) ? src[si][63:0] : '0;
      oready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (fm) chk("sdp_ready_idle", 76'(srdy), 76'd0);
      else    chk("rdma_ready_idle", 76'(rrdy), 76'd0);
      chk("done_early", 76'(done), 76'd0);
      if (v && (fm ? rrdy : srdy)) si++;
      if (ovld && !oready) stall_e++;
      if (ovld && oready) begin
        chk("beat", opd, expq[oi]);
        lf = opd[75:64];
        oi++;
        nb++;
      end
      tick();
      cyc++;
    end
    chk("layer_beats", 76'(oi), 76'(expq.size()));
    chk("done_pulse", 76'(done), 76'd1);
    chk("busy_fall", 76'(busy), 76'd0);
    chk("out_empty", 76'(ovld), 76'd0);
    chk("perf_stall", 76'(stall), 76'(stall_e));
    chk("accepted", 76'(si), 76'(expq.size()));
    rvld = 1'b0; svld = 1'b0;
    op_en = poke;
    tick();
    op_en = 1'b0;
    chk("done_once", 76'(done), 76'd0);
    chk("busy_after", 76'(busy), 76'd0);
    chk("perf_hold", 76'(stall), 76'(stall_e));
  endtask

  typedef struct {
    bit          fm;
    logic [1:0]  dt;
    logic [12:0] w, h, c;
    int          nb;
    logic [11:0] lf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [63:0] dq[8];
    int nb, k, o, cyc;
    logic [11:0] lf;
    tbl[0] = '{1'b0, 2'd0, 13'd1, 13'd0, 13'd15,   4,    12'h01F};
    tbl[1] = '{1'b0, 2'd1, 13'd1, 13'd0, 13'd15,   8,    12'h03F};
    tbl[2] = '{1'b0, 2'd0, 13'd0, 13'd0, 13'd0,    1,    12'h00F};
    tbl[3] = '{1'b0, 2'd0, 13'd0, 13'd0, 13'd8191, 1024, 12'h1FF};
    tbl[4] = '{1'b1, 2'd3, 13'd4, 13'd4, 13'd4,    5,    12'hE1C};
    tbl[5] = '{1'b0, 2'd2, 13'd3, 13'd2, 13'd20,   72,   12'h05F};
    tbl[6] = '{1'b0, 2'd0, 13'd2, 13'd1, 13'd9,    12,   12'h01F};

    rst = 1'b1; op_en = 1'b0; fly = 1'b0; dtype = '0; cw = '0; ch = '0; cc = '0;
    rvld = 1'b0; rpd = '0; svld = 1'b0; spd = '0; oready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 76'(ovld), 76'd0);
    chk("rst_pd", opd, 76'd0);
    chk("rst_busy", 76'(busy), 76'd0);
    chk("rst_done", 76'(done), 76'd0);
    chk("rst_stall", 76'(stall), 76'd0);
    chk("rst_rdy", 76'({rrdy, srdy}), 76'd0);

    for (int i = 0; i < 7; i++) begin
      run_layer(tbl[i].fm, tbl[i].dt, tbl[i].w, tbl[i].h, tbl[i].c, 75, 85, i == 0, nb, lf);
      chk("tbl_beats", 76'(nb), 76'(tbl[i].nb));
      chk("tbl_last_flags", 76'(lf), 76'(tbl[i].lf));
    end

    // Back-pressure: output stalled 10 cycles while SDP keeps offering beats.
    for (int i = 0; i < 8; i++) dq[i] = {$urandom, $urandom};
    fly = 1'b0; dtype = 2'd0; cw = 13'd7; ch = 13'd0; cc = 13'd7;
    op_en = 1'b1;
    tick();
    op_en = 1'b0; oready = 1'b0; svld = 1'b1; k = 0;
    for (int c = 0; c < 10; c++) begin
      spd = dq[k];
      @(negedge clk);
      if (srdy) k++;
      tick();
    end
    chk("bp_accepted", 76'(k), 76'd2);
    chk("bp_stall", 76'(stall), 76'd9);
    oready = 1'b1; o = 0; cyc = 0;
    while (o < 8 && cyc < 60) begin
      svld = (k < 8);
      spd  = (k < 8) ? dq[k] : '0;
      @(negedge clk);
      if (svld && srdy) k++;
      if (ovld) begin
        chk("bp_beat", opd, {(o == 7) ? 12'h00F : 12'h000, dq[o]});
        o++;
      end
      tick();
      cyc++;
    end
    svld = 1'b0;
    chk("bp_count", 76'(o), 76'd8);
    chk("bp_done", 76'(done), 76'd1);
    chk("bp_stall_final", 76'(stall), 76'd9);
    tick();

    // Reset after 3 of 8 beats: everything clears and no done follows.
    op_en = 1'b1;
    tick();
    op_en = 1'b0; svld = 1'b1; oready = 1'b1; k = 0; cyc = 0;
    while (k < 3 && cyc < 20) begin
      spd = {$urandom, $urandom};
      @(negedge clk);
      if (srdy) k++;
      tick();
      cyc++;
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 76'(ovld), 76'd0);
    chk("mid_rst_pd", opd, 76'd0);
    chk("mid_rst_busy", 76'(busy), 76'd0);
    chk("mid_rst_stall", 76'(stall), 76'd0);
    chk("mid_rst_rdy", 76'({rrdy, srdy}), 76'd0);
    rst = 1'b0; svld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_no_done", 76'(done), 76'd0);
    end
    run_layer(1'b0, 2'd0, 13'd7, 13'd0, 13'd7, 100, 100, 1'b0, nb, lf);
    chk("post_rst_beats", 76'(nb), 76'd8);

    // Random layers.
    for (int r = 0; r < 10; r++) begin
      run_layer(1'($urandom_range(1)), 2'($urandom_range(3)), 13'($urandom_range(3)),
                13'($urandom_range(2)), 13'($urandom_range(40)),
                $urandom_range(100, 30), $urandom_range(100, 30), 1'b0, nb, lf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
